// File: rtl/recog_pkg.sv
// Shared constants and state encoding for the
// digit-recognition match sequencer.
package recog_pkg;

   localparam int ROWS          = 16;
   localparam int COLS          = 16;
   localparam int NUM_TPL       = 10;
   localparam int REJECT_THRESH = 64;
   localparam int ROW_AW        = 4;
   localparam int IDX_W         = 4;
   localparam int SCORE_W       = 9;
   localparam int PC_W          = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      ARGMIN = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/recog_match_seq_if.sv
// Bus between the image/template sources, the
// sequencer and the result display.
interface recog_match_seq_if;
   import recog_pkg::*;

   logic                    start;
   logic                    busy;
   logic [ROW_AW-1:0]       row_addr;
   logic [0:COLS-1]         img_row;
   logic [NUM_TPL*COLS-1:0] tpl_rows;
   logic                    done;
   logic [IDX_W-1:0]        result;
   logic [SCORE_W-1:0]      best_score;
   logic                    no_match;

   modport master (
      output start, img_row, tpl_rows,
      input  busy, row_addr, done,
      input  result, best_score, no_match
   );

   modport slave (
      input  start, img_row, tpl_rows,
      output busy, row_addr, done,
      output result, best_score, no_match
   );

endinterface

// File: rtl/row_mismatch.sv
// Pixel mismatch count of one bitmap row against
// one template row.
module row_mismatch
   import recog_pkg::*;
(
   input  logic [0:COLS-1] a,
   input  logic [0:COLS-1] b,
   output logic [PC_W-1:0] cnt
);

   logic [0:COLS-1] diff;

   assign diff = a ^ b;

   // popcount of the differing pixels
   always_comb begin
      cnt = '0;
      for (int i = 0; i < COLS; i++)
         cnt = cnt + PC_W'(diff[i]);
   end

endmodule

// File: rtl/recog_match_seq.sv
// Scans the drawn bitmap against every template,
// then picks the lowest mismatch score serially.
module recog_match_seq
   import recog_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   recog_match_seq_if.slave  bus
);

   localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(ROWS-1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_TPL-1);

   state_t              state, state_nx;
   logic [ROW_AW-1:0]   row;
   logic [IDX_W-1:0]    idx;
   logic [SCORE_W-1:0]  acc [NUM_TPL];
   logic [PC_W-1:0]     pc  [NUM_TPL];
   logic [SCORE_W-1:0]  best, cur, win_s;
   logic [IDX_W-1:0]    arg, win_i;
   logic                take;
   logic [SCORE_W-1:0]  res_s;
   logic [IDX_W-1:0]    res_i;
   logic                res_nm;
   logic                busy_c, done_c;
   logic [ROW_AW-1:0]   addr_c;

   for (genvar k = 0; k < NUM_TPL; k++) begin : g_mm
      row_mismatch u_mm (
         .a   (bus.img_row),
         .b   (bus.tpl_rows[k*COLS +: COLS]),
         .cnt (pc[k])
      );
   end

   // single shared comparator; idx 0 always seeds
   assign cur   = acc[idx];
   assign take  = (idx == '0) || (cur < best);
   assign win_s = take ? cur : best;
   assign win_i = take ? idx : arg;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state and handshake outputs
   always_comb begin
      state_nx = state;
      busy_c   = 1'b1;
      done_c   = 1'b0;
      addr_c   = '0;
      unique case (state)
         IDLE: begin
            busy_c = 1'b0;
            if (bus.start) state_nx = SCAN;
         end
         SCAN: begin
            addr_c = row;
            if (row == ROW_LAST) state_nx = ARGMIN;
         end
         ARGMIN: begin
            if (idx == IDX_LAST) state_nx = DONE;
         end
         DONE: begin
            done_c   = 1'b1;
            state_nx = IDLE;
         end
      endcase
   end

   // counters, accumulators and argmin/result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         row    <= '0;
         idx    <= '0;
         best   <= '0;
         arg    <= '0;
         res_s  <= '0;
         res_i  <= '0;
         res_nm <= 1'b0;
         for (int k = 0; k < NUM_TPL; k++) acc[k] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  row <= '0;
                  for (int k = 0; k < NUM_TPL; k++) acc[k] <= '0;
               end
            end
            SCAN: begin
               for (int k = 0; k < NUM_TPL; k++)
                  acc[k] <= acc[k] + SCORE_W'(pc[k]);
               row <= row + 1'b1;
               if (row == ROW_LAST) idx <= '0;
            end
            ARGMIN: begin
               best <= win_s;
               arg  <= win_i;
               idx  <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  res_s  <= win_s;
                  res_i  <= win_i;
                  res_nm <= win_s > SCORE_W'(REJECT_THRESH);
               end
            end
            DONE: begin
            end
         endcase
      end
   end

   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.row_addr   = addr_c;
   assign bus.result     = res_i;
   assign bus.best_score = res_s;
   assign bus.no_match   = res_nm;

endmodule

// File: tb/tb_recog_match_seq.sv
// Directed bench for recog_match_seq with a result
// scoreboard and per-cycle handshake checks.
module tb_recog_match_seq;
   import recog_pkg::*;

   typedef struct {
      logic [3:0] r;
      logic [8:0] s;
      logic       nm;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t q[$];

   logic [0:15] img_m [16];
   logic [0:15] tpl_m [10][16];

   recog_match_seq_if bus ();

   recog_match_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM / image buffer model: combinational row read
   always_comb begin
      bus.img_row  = img_m[bus.row_addr];
      bus.tpl_rows = '0;
      for (int k = 0; k < 10; k++)
         bus.tpl_rows[k*16 +: 16] = tpl_m[k][bus.row_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
      end
   endtask

   function automatic exp_t model();
      exp_t e;
      int   s, bs, bi;
      bs = 1 << 30;
      bi = 0;
      for (int k = 0; k < 10; k++) begin
         s = 0;
         for (int r = 0; r < 16; r++)
            s += $countones(img_m[r] ^ tpl_m[k][r]);
         if (s < bs) begin
            bs = s;
            bi = k;
         end
      end
      e.r  = 4'(bi);
      e.s  = 9'(bs);
      e.nm = (bs > 64);
      return e;
   endfunction

   task automatic fill_img(input int mode);
      for (int r = 0; r < 16; r++)
         img_m[r] = (mode == 0) ? 16'h0000 :
                    (mode == 1) ? 16'hFFFF :
                    16'($urandom);
   endtask

   // template k = image with n distinct pixels flipped
   task automatic set_tpl(input int k, input int n);
      int pos;
      for (int r = 0; r < 16; r++) tpl_m[k][r] = img_m[r];
      for (int p = 0; p < n; p++) begin
         pos = (p * 37 + k * 11) % 256;
         tpl_m[k][pos / 16][pos % 16] =
            ~tpl_m[k][pos / 16][pos % 16];
      end
   endtask

   task automatic rand_tpl(input int k);
      for (int r = 0; r < 16; r++)
         tpl_m[k][r] = 16'($urandom);
   endtask

   // mode 0: start pulse; 1: start held to cycle 27;
   // 2: extra start pulses in cycles 5 and 27
   task automatic run_pass(input string tag, input int mode);
      exp_t e;
      int   ndone;
      ndone = 0;
      q.push_back(model());
      bus.start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 28; c++) begin
         bus.start = (mode == 1 && c <= 27) ||
                     (mode == 2 && (c == 5 || c == 27));
         chk({tag, "_busy"}, 32'(bus.busy),
             32'(c <= 27));
         chk({tag, "_row"}, 32'(bus.row_addr),
             (c <= 16) ? 32'(c - 1) : 32'd0);
         chk({tag, "_done"}, 32'(bus.done),
             32'(c == 27));
         if (bus.done === 1'b1) begin
            ndone++;
            if (q.size() == 0) begin
               chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
               e = q.pop_front();
               chk({tag, "_result"}, 32'(bus.result),
                   32'(e.r));
               chk({tag, "_score"}, 32'(bus.best_score),
                   32'(e.s));
               chk({tag, "_nomatch"}, 32'(bus.no_match),
                   32'(e.nm));
            end
         end
         if (c < 28) begin
            @(posedge clk); #1;
         end
      end
      bus.start = 1'b0;
      chk({tag, "_ndone"}, 32'(ndone), 32'd1);
      chk({tag, "_held"}, 32'(bus.result), 32'(e.r));
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      fill_img(0);
      for (int k = 0; k < 10; k++) set_tpl(k, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_row", 32'(bus.row_addr), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_score", 32'(bus.best_score), 32'd0);
      chk("rst_nomatch", 32'(bus.no_match), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // exact match on template 1
      fill_img(2);
      for (int k = 0; k < 10; k++) rand_tpl(k);
      set_tpl(1, 0);
      run_pass("t1_exact", 0);

      // tie between 3 and 7 goes to 3
      fill_img(2);
      for (int k = 0; k < 10; k++) set_tpl(k, 20 + 3 * k);
      set_tpl(3, 5);
      set_tpl(7, 5);
      run_pass("t2_tie", 2);

      // all far: reject, start held high
      fill_img(1);
      for (int k = 0; k < 10; k++) set_tpl(k, 80 + k);
      run_pass("t3_reject", 1);

      // threshold boundary 64 accepted (starts cycle 28)
      for (int k = 0; k < 10; k++) set_tpl(k, 100);
      set_tpl(4, 64);
      run_pass("t3_b64", 0);

      // 65 rejected
      set_tpl(4, 100);
      set_tpl(9, 65);
      run_pass("t3_b65", 0);

      // reset in cycle 10 aborts and clears results
      fill_img(2);
      for (int k = 0; k < 10; k++) set_tpl(k, 30 + k);
      set_tpl(6, 12);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      chk("t5_row_c10", 32'(bus.row_addr), 32'd9);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_row", 32'(bus.row_addr), 32'd0);
      chk("t5_result", 32'(bus.result), 32'd0);
      chk("t5_score", 32'(bus.best_score), 32'd0);
      chk("t5_nomatch", 32'(bus.no_match), 32'd0);
      for (int c = 0; c < 30; c++) begin
         chk("t5_nodone", 32'(bus.done), 32'd0);
         @(posedge clk); #1;
      end
      run_pass("t5_fresh", 0);

      // full-scale 256 mismatches, no overflow
      fill_img(0);
      for (int k = 0; k < 10; k++) set_tpl(k, 256);
      run_pass("t6_max", 0);

      chk("sb_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
